// File: rtl/param_queue.sv
// Parametrised single-clock FIFO with occupancy count, programmable watermarks,
// sticky overflow/underflow flags, synchronous flush and a registered read strobe.
module param_queue #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int AF_LEVEL = 2**ADDR_W - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic              Flush_i,
  input  logic              WrEn_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              RdEn_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int             DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AF_CNT  = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT  = (ADDR_W+1)'(AE_LEVEL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                    (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
  assign w_rd_acc = RdEn_i & ~w_empty;
  assign w_wr_acc = WrEn_i & (~w_full | w_rd_acc);

  // Storage is not reset, so it can map onto plain RAM.
  always_ff @(posedge Clk_i) begin
    if (w_wr_acc && !Flush_i) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= data_i;
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (Flush_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_data   <= r_mem[r_rd_ptr[ADDR_W-1:0]];
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + PTR_ONE;
      end else if (w_rd_acc && !w_wr_acc) begin
        r_count <= r_count - PTR_ONE;
      end
      if (WrEn_i && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end
      if (RdEn_i && !w_rd_acc) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign data_o         = r_data;
  assign valid_o        = r_valid;
  assign empty_o        = w_empty;
  assign full_o         = w_full;
  assign almost_empty_o = (r_count <= AE_CNT);
  assign almost_full_o  = (r_count >= AF_CNT);
  assign count_o        = r_count;
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;

endmodule

// File: tb/tb_param_queue.sv
// Directed bench for param_queue with DEPTH 4, AF_LEVEL 3, AE_LEVEL 1.
module tb_param_queue;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic [7:0] dout;
  logic       valid;
  logic       empty;
  logic       full;
  logic       aempty;
  logic       afull;
  logic [2:0] count;
  logic       ovf;
  logic       udf;

  int n_vec = 0;
  int n_err = 0;

  param_queue #(
    .DATA_W(8), .ADDR_W(2), .AF_LEVEL(3), .AE_LEVEL(1)
  ) dut (
    .Clk_i(clk), .Rst_i(rst), .Flush_i(flush), .WrEn_i(wr_en), .data_i(din),
    .RdEn_i(rd_en), .data_o(dout), .valid_o(valid), .empty_o(empty),
    .full_o(full), .almost_empty_o(aempty), .almost_full_o(afull),
    .count_o(count), .overflow_o(ovf), .underflow_o(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r);
    wr_en = w;
    din   = d;
    rd_en = r;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; drive(1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    step();

    // 1: reset then idle
    chk("rst_data", dout, 8'h00);
    chk("rst_count", count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_aempty", aempty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_afull", afull, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_udf", udf, 1'b0);

    // 2: fill then drain
    drive(1'b1, 8'h11, 1'b0); step();
    chk("f1_count", count, 3'd1); chk("f1_empty", empty, 1'b0); chk("f1_aempty", aempty, 1'b1);
    drive(1'b1, 8'h22, 1'b0); step();
    chk("f2_count", count, 3'd2); chk("f2_aempty", aempty, 1'b0); chk("f2_afull", afull, 1'b0);
    drive(1'b1, 8'h33, 1'b0); step();
    chk("f3_count", count, 3'd3); chk("f3_afull", afull, 1'b1); chk("f3_full", full, 1'b0);
    drive(1'b1, 8'h44, 1'b0); step();
    chk("f4_count", count, 3'd4); chk("f4_full", full, 1'b1);
    drive(1'b0, 8'h00, 1'b1); step();
    chk("r1_data", dout, 8'h11); chk("r1_valid", valid, 1'b1); chk("r1_count", count, 3'd3);
    step();
    chk("r2_data", dout, 8'h22); chk("r2_valid", valid, 1'b1);
    step();
    chk("r3_data", dout, 8'h33); chk("r3_valid", valid, 1'b1);
    step();
    chk("r4_data", dout, 8'h44); chk("r4_valid", valid, 1'b1); chk("r4_empty", empty, 1'b1);
    drive(1'b0, 8'h00, 1'b0); step();
    chk("idle_valid", valid, 1'b0); chk("idle_hold", dout, 8'h44);

    // 4: full queue, simultaneous write and read, then drain through wrap
    drive(1'b1, 8'h11, 1'b0); step();
    drive(1'b1, 8'h22, 1'b0); step();
    drive(1'b1, 8'h33, 1'b0); step();
    drive(1'b1, 8'h44, 1'b0); step();
    chk("s4_full", full, 1'b1);
    drive(1'b1, 8'h66, 1'b1); step();
    chk("s4_data", dout, 8'h11); chk("s4_count", count, 3'd4);
    chk("s4_full2", full, 1'b1); chk("s4_ovf", ovf, 1'b0);
    drive(1'b0, 8'h00, 1'b1); step();
    chk("s4_r2", dout, 8'h22);
    step(); chk("s4_r3", dout, 8'h33);
    step(); chk("s4_r4", dout, 8'h44);
    step(); chk("s4_r5", dout, 8'h66); chk("s4_empty", empty, 1'b1);

    // 3: overflow on a full queue
    drive(1'b1, 8'h11, 1'b0); step();
    drive(1'b1, 8'h22, 1'b0); step();
    drive(1'b1, 8'h33, 1'b0); step();
    drive(1'b1, 8'h44, 1'b0); step();
    drive(1'b1, 8'h55, 1'b0); step();
    chk("s3_ovf", ovf, 1'b1); chk("s3_count", count, 3'd4);
    drive(1'b0, 8'h00, 1'b0); step();
    chk("s3_ovf_sticky", ovf, 1'b1);
    drive(1'b0, 8'h00, 1'b1); step();
    chk("s3_data", dout, 8'h11); chk("s3_count2", count, 3'd3); chk("s3_ovf_hold", ovf, 1'b1);

    // 6a: flush with count 3 and overflow set, write ignored
    drive(1'b1, 8'h99, 1'b0); flush = 1'b1; step();
    flush = 1'b0; drive(1'b0, 8'h00, 1'b0);
    chk("fl_count", count, 3'd0); chk("fl_empty", empty, 1'b1);
    chk("fl_ovf", ovf, 1'b0); chk("fl_valid", valid, 1'b0); chk("fl_data", dout, 8'h11);
    step();
    chk("fl_count2", count, 3'd0);

    // 5: simultaneous read and write on an empty queue
    drive(1'b1, 8'h77, 1'b1); step();
    chk("s5_udf", udf, 1'b1); chk("s5_valid", valid, 1'b0);
    chk("s5_count", count, 3'd1); chk("s5_hold", dout, 8'h11);
    drive(1'b0, 8'h00, 1'b1); step();
    chk("s5_data", dout, 8'h77); chk("s5_valid2", valid, 1'b1); chk("s5_udf_sticky", udf, 1'b1);

    // 6b: asynchronous reset mid-cycle
    drive(1'b1, 8'hA1, 1'b0); step();
    drive(1'b1, 8'hA2, 1'b0); step();
    drive(1'b0, 8'h00, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0);
    chk("pre_data", dout, 8'hA1); chk("pre_valid", valid, 1'b1); chk("pre_count", count, 3'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_data", dout, 8'h00); chk("ar_valid", valid, 1'b0); chk("ar_count", count, 3'd0);
    chk("ar_empty", empty, 1'b1); chk("ar_aempty", aempty, 1'b1); chk("ar_udf", udf, 1'b0);
    chk("ar_afull", afull, 1'b0);
    step();
    #2 rst = 1'b0;
    step();
    drive(1'b1, 8'hB1, 1'b0); step();
    chk("resume_count", count, 3'd1);
    drive(1'b0, 8'h00, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0);
    chk("resume_data", dout, 8'hB1); chk("resume_valid", valid, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_queue.md
Name: param_queue

Overview:
- Parametrised synchronous FIFO queue; successor to the 8-bit, 256-entry single-port-command queue.
- Generalised data width and depth; independent read and write enables, usable in the same cycle.
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, synchronous flush and a registered read-data valid strobe.
- Sits between producer and consumer blocks in the same clock domain.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, address width; depth DEPTH = 2**ADDR_W entries.
- AF_LEVEL, 2**ADDR_W-1, almost_full_o asserts when count >= AF_LEVEL.
- AE_LEVEL, 1, almost_empty_o asserts when count <= AE_LEVEL.

Ports:
- Clk_i  in  1  clock; all state updates on rising edge.
- Rst_i  in  1  asynchronous, active-high reset.
- Flush_i  in  1  synchronous clear of queue contents and error flags.
- WrEn_i  in  1  write request.
- data_i  in  DATA_W  write data.
- RdEn_i  in  1  read request.
- data_o  out  DATA_W  read data; registered.
- valid_o  out  1  data_o updated by a read accepted in the previous cycle.
- empty_o  out  1  count == 0.
- full_o  out  1  count == DEPTH.
- almost_empty_o  out  1  count <= AE_LEVEL.
- almost_full_o  out  1  count >= AF_LEVEL.
- count_o  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: write attempted while not accepted.
- underflow_o  out  1  sticky: read attempted while empty.

Behaviour:
- Storage: DEPTH x DATA_W register array. Write and read pointers are ADDR_W+1 bits wide; the low ADDR_W bits address the array and the MSB is the wrap bit.
- Status decode: empty when pointers are fully equal; full when the low bits are equal and the wrap bits differ.
- count_o is a registered counter: +1 on an accepted write only, -1 on an accepted read only, unchanged on both or neither.
- rd_acc = RdEn_i & !empty_o.
- wr_acc = WrEn_i & (!full_o | rd_acc). A write to a full queue is accepted only when a read is accepted in the same cycle.
- Accepted write: mem[wr_ptr] <= data_i; wr_ptr increments, wrapping naturally at 2**(ADDR_W+1).
- Accepted read: data_o <= mem[rd_ptr]; rd_ptr increments; valid_o = 1 next cycle, otherwise valid_o = 0.
- data_o holds its last value when no read is accepted.
- Latency:
  - Write-to-read: a word written at edge N is readable (empty_o = 0) after edge N and appears on data_o after the read edge.
  - Read latency is 1 clock.
- Simultaneous read and write when empty: the read is rejected (no fall-through), underflow_o is set, and the write is accepted.
- Simultaneous read and write when full: both accepted; count stays at DEPTH; full_o stays 1.
- Error flags: overflow_o sets on WrEn_i & !wr_acc; underflow_o sets on RdEn_i & !rd_acc. Both hold until Flush_i or Rst_i.
- Flush_i: on the next edge, pointers = 0, count = 0, overflow_o = underflow_o = 0, valid_o = 0, and data_o is unchanged. It overrides WrEn_i and RdEn_i in the same cycle. Array contents are not cleared.
- Rst_i (asynchronous, any time including mid-transfer):
  - Pointers, count_o, data_o = 0; valid_o = 0; overflow_o = underflow_o = 0.
  - Resulting flag outputs: empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = (AF_LEVEL == 0).
  - Array contents are not reset.
  - Operation resumes on the first edge after Rst_i deasserts.
- All flag outputs are combinational decodes of registered pointers and count only, with no input-to-output combinational paths.

Test Plan:
All scenarios use DATA_W=8, ADDR_W=2 (DEPTH 4), AF_LEVEL=3, AE_LEVEL=1.
1. Reset then idle -> data_o=0x00, count_o=0, empty_o=1, almost_empty_o=1, full_o=0, valid_o=0, both error flags 0.
2. Write 0x11, 0x22, 0x33, 0x44 on consecutive edges -> count_o steps 1,2,3,4; almost_empty_o drops after count=2; almost_full_o rises at count=3; full_o=1 at count=4. Then read 4 times -> data_o = 0x11, 0x22, 0x33, 0x44, each one cycle after its RdEn_i, with valid_o=1 on each; empty_o=1 at the end.
3. Full queue, WrEn_i=1 with 0x55 and RdEn_i=0 -> overflow_o=1 and stays set, count_o=4. The next read returns 0x11, not 0x55.
4. Full queue, WrEn_i=1 (0x66) and RdEn_i=1 in the same cycle -> data_o=0x11, count_o stays 4, no overflow. Reads continue through the wrap-around and 0x66 emerges last.
5. Empty queue, RdEn_i=1 and WrEn_i=1 (0x77) in the same cycle -> underflow_o=1, valid_o=0, count_o=1. The following read returns 0x77.
6. With count=3 and overflow_o set, pulse Flush_i together with WrEn_i -> count_o=0, empty_o=1, overflow_o=0, and the write is ignored. Separately, assert Rst_i asynchronously mid-cycle -> outputs go to their reset values before the next edge.
